// File: rtl/chan_mux_seq.sv
// Registered N-channel mux: manual select or fixed-dwell time-division scan.
// Latency: 1 cycle from din/sel_in/mode to q, sel_out and strobe.
// No backpressure: en=0 freezes all state and forces strobe low.
module chan_mux_seq #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 4,
  localparam int SELW    = ($clog2(CHANNELS) < 1) ? 1 : $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      mode,
  input  logic [SELW-1:0]           sel_in,
  input  logic [CHANNELS*WIDTH-1:0] din,
  output logic [WIDTH-1:0]          q,
  output logic [SELW-1:0]           sel_out,
  output logic                      strobe
);

  localparam int DCW = ($clog2(DWELL) < 1) ? 1 : $clog2(DWELL);
  localparam logic [SELW-1:0] LAST_SEL = SELW'(CHANNELS - 1);
  localparam logic [DCW-1:0]  LAST_D   = DCW'(DWELL - 1);

  logic [DCW-1:0]   dcnt;
  logic [DCW-1:0]   next_dcnt;
  logic [SELW-1:0]  next_sel;
  logic             mode_q;
  logic [WIDTH-1:0] next_word;

  // Channel selection: manual pick (out-of-range holds), or dwell-paced scan.
  // A fresh entry into scan keeps the current channel and restarts its dwell.
  always_comb begin
    next_sel  = sel_out;
    next_dcnt = '0;
    if (mode) begin
      if (mode_q) begin
        if (dcnt == LAST_D) begin
          next_sel = (sel_out == LAST_SEL) ? '0 : sel_out + SELW'(1);
        end else begin
          next_dcnt = dcnt + DCW'(1);
        end
      end
    end else if (int'(sel_in) < CHANNELS) begin
      next_sel = sel_in;
    end
  end

  // Word mux for the channel about to be registered.
  always_comb begin
    next_word = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (next_sel == SELW'(k)) begin
        next_word = din[k*WIDTH +: WIDTH];
      end
    end
  end

  // Register word and index together so they always describe the same channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      q       <= '0;
      sel_out <= '0;
      strobe  <= 1'b0;
      dcnt    <= '0;
      mode_q  <= 1'b0;
    end else if (en) begin
      q       <= next_word;
      sel_out <= next_sel;
      strobe  <= (next_sel != sel_out);
      dcnt    <= next_dcnt;
      mode_q  <= mode;
    end else begin
      strobe  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_chan_mux_seq.sv
// Directed bench for chan_mux_seq: a 4-channel/DWELL=4 instance and a
// 3-channel/DWELL=1 instance share clock, reset and enable.
// Each check compares {q, sel_out, strobe} against hand-computed values.
module tb_chan_mux_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        mode, mode3;
  logic [1:0]  sel_in, sel_in3;
  logic [31:0] din;
  logic [23:0] din3;
  logic [7:0]  q, q3;
  logic [1:0]  sel_out, sel_out3;
  logic        strobe, strobe3;

  int tests = 0;
  int fails = 0;

  logic [7:0] w4 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  always #5 clk = ~clk;

  chan_mux_seq #(.WIDTH(8), .CHANNELS(4), .DWELL(4)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_in(sel_in),
    .din(din), .q(q), .sel_out(sel_out), .strobe(strobe)
  );

  chan_mux_seq #(.WIDTH(8), .CHANNELS(3), .DWELL(1)) dut3 (
    .clk(clk), .rst(rst), .en(en), .mode(mode3), .sel_in(sel_in3),
    .din(din3), .q(q3), .sel_out(sel_out3), .strobe(strobe3)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [10:0] exp;
    rst = 1'b1; en = 1'b0; mode = 1'b0; mode3 = 1'b1;
    sel_in = 2'd3; sel_in3 = 2'd2;
    din = 32'hDEADBEEF; din3 = 24'hA5A5A5;
    step();
    en = 1'b1;
    step();
    exp = {8'h00, 2'd0, 1'b0};
    tests++;
    if ({q, sel_out, strobe} !== exp) begin
      fails++;
      $display("FAIL reset4: got %h want %h", {q, sel_out, strobe}, exp);
    end
    tests++;
    if ({q3, sel_out3, strobe3} !== exp) begin
      fails++;
      $display("FAIL reset3: got %h want %h", {q3, sel_out3, strobe3}, exp);
    end
    mode = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      tests++;
      if ({q, sel_out, strobe} !== exp) begin
        fails++;
        $display("FAIL reset_hold cyc %0d: got %h want %h", i, {q, sel_out, strobe}, exp);
      end
    end
  endtask

  task automatic test_manual();
    rst = 1'b0; en = 1'b1; mode = 1'b0; mode3 = 1'b0; sel_in3 = 2'd0;
    din = {w4[3], w4[2], w4[1], w4[0]};
    sel_in = 2'd2;
    step();
    tests++;
    if ({q, sel_out, strobe} !== {8'h33, 2'd2, 1'b1}) begin
      fails++;
      $display("FAIL manual_sel: got %h/%0d/%b want 33/2/1", q, sel_out, strobe);
    end
    step();
    tests++;
    if ({q, sel_out, strobe} !== {8'h33, 2'd2, 1'b0}) begin
      fails++;
      $display("FAIL manual_hold: got %h/%0d/%b want 33/2/0", q, sel_out, strobe);
    end
    din[23:16] = 8'h5A;
    step();
    tests++;
    if ({q, sel_out, strobe} !== {8'h5A, 2'd2, 1'b0}) begin
      fails++;
      $display("FAIL manual_data: got %h/%0d/%b want 5a/2/0", q, sel_out, strobe);
    end
    din[23:16] = w4[2];
    step();
  endtask

  task automatic test_out_of_range();
    din3 = 24'hCCBBAA;
    sel_in3 = 2'd1;
    step();
    tests++;
    if ({q3, sel_out3, strobe3} !== {8'hBB, 2'd1, 1'b1}) begin
      fails++;
      $display("FAIL oor_setup: got %h/%0d/%b want bb/1/1", q3, sel_out3, strobe3);
    end
    sel_in3 = 2'd3;
    step();
    tests++;
    if ({q3, sel_out3, strobe3} !== {8'hBB, 2'd1, 1'b0}) begin
      fails++;
      $display("FAIL oor_hold: got %h/%0d/%b want bb/1/0", q3, sel_out3, strobe3);
    end
    din3[15:8] = 8'hB7;
    step();
    tests++;
    if ({q3, sel_out3, strobe3} !== {8'hB7, 2'd1, 1'b0}) begin
      fails++;
      $display("FAIL oor_data: got %h/%0d/%b want b7/1/0", q3, sel_out3, strobe3);
    end
  endtask

  task automatic test_scan_wrap();
    logic [1:0] es;
    logic       est;
    mode = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      step();
      es  = 2'((2 + (i - 1) / 4) % 4);
      est = (i > 1) && ((i - 1) % 4 == 0);
      tests++;
      if ({q, sel_out, strobe} !== {w4[es], es, est}) begin
        fails++;
        $display("FAIL scan edge %0d: got %h/%0d/%b want %h/%0d/%b",
                 i, q, sel_out, strobe, w4[es], es, est);
      end
    end
  endtask

  task automatic test_enable_pause();
    step();
    tests++;
    if ({q, sel_out, strobe} !== {8'h33, 2'd2, 1'b0}) begin
      fails++;
      $display("FAIL pause_pre: got %h/%0d/%b want 33/2/0", q, sel_out, strobe);
    end
    en = 1'b0;
    din[23:16] = 8'h99;
    for (int i = 0; i < 5; i++) begin
      step();
      tests++;
      if ({q, sel_out, strobe} !== {8'h33, 2'd2, 1'b0}) begin
        fails++;
        $display("FAIL pause cyc %0d: got %h/%0d/%b want 33/2/0", i, q, sel_out, strobe);
      end
    end
    en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      tests++;
      if (i < 3 && {q, sel_out, strobe} !== {8'h99, 2'd2, 1'b0}) begin
        fails++;
        $display("FAIL resume edge %0d: got %h/%0d/%b want 99/2/0", i, q, sel_out, strobe);
      end
      if (i == 3 && {q, sel_out, strobe} !== {8'h44, 2'd3, 1'b1}) begin
        fails++;
        $display("FAIL resume_adv: got %h/%0d/%b want 44/3/1", q, sel_out, strobe);
      end
    end
    din[23:16] = w4[2];
  endtask

  task automatic test_mode_switch();
    step();
    step();
    mode = 1'b0; sel_in = 2'd3;
    step();
    tests++;
    if ({q, sel_out, strobe} !== {8'h44, 2'd3, 1'b0}) begin
      fails++;
      $display("FAIL leave_same: got %h/%0d/%b want 44/3/0", q, sel_out, strobe);
    end
    mode = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      tests++;
      if (i < 5 && {q, sel_out, strobe} !== {8'h44, 2'd3, 1'b0}) begin
        fails++;
        $display("FAIL reenter edge %0d: got %h/%0d/%b want 44/3/0", i, q, sel_out, strobe);
      end
      if (i == 5 && {q, sel_out, strobe} !== {8'h11, 2'd0, 1'b1}) begin
        fails++;
        $display("FAIL reenter_wrap: got %h/%0d/%b want 11/0/1", q, sel_out, strobe);
      end
    end
    mode = 1'b0; sel_in = 2'd1;
    step();
    tests++;
    if ({q, sel_out, strobe} !== {8'h22, 2'd1, 1'b1}) begin
      fails++;
      $display("FAIL leave_change: got %h/%0d/%b want 22/1/1", q, sel_out, strobe);
    end
  endtask

  task automatic test_dwell1();
    logic [1:0] es [4] = '{2'd1, 2'd2, 2'd0, 2'd1};
    logic [7:0] ew [4] = '{8'hB7, 8'hCC, 8'hAA, 8'hB7};
    mode3 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      tests++;
      if ({q3, sel_out3, strobe3} !== {ew[i], es[i], (i != 0)}) begin
        fails++;
        $display("FAIL dwell1 edge %0d: got %h/%0d/%b want %h/%0d/%b",
                 i, q3, sel_out3, strobe3, ew[i], es[i], (i != 0));
      end
    end
  endtask

  task automatic test_reset_scan_start();
    mode = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      step();
      tests++;
      if (i < 5 && {q, sel_out, strobe} !== {8'h11, 2'd0, 1'b0}) begin
        fails++;
        $display("FAIL post_reset edge %0d: got %h/%0d/%b want 11/0/0", i, q, sel_out, strobe);
      end
      if (i == 5 && {q, sel_out, strobe} !== {8'h22, 2'd1, 1'b1}) begin
        fails++;
        $display("FAIL post_reset_adv: got %h/%0d/%b want 22/1/1", q, sel_out, strobe);
      end
    end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_out_of_range();
    test_scan_wrap();
    test_enable_pause();
    test_mode_switch();
    test_dwell1();
    test_reset_scan_start();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
